// File: rtl/i2c_master_ctrl.sv
// Single-byte open-drain I2C master: START, address, one data byte, STOP.
// Four quarter phases per SCL bit; the slave may stretch SCL during Q2.
module i2c_master_ctrl #(
  parameter int CLK_DIV   = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET_IN,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_RW,
  input  logic [6:0] CMD_ADDR,
  input  logic [7:0] CMD_WDATA,
  output logic [7:0] RD_DATA,
  output logic       RD_VALID,
  output logic       DONE,
  output logic       ACK_ERR,
  output logic       BUSY,
  inout  wire        SCL,
  inout  wire        SDA
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE,
    S_WRITE_ACK,
    S_READ,
    S_READ_ACK,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      abyte_q, abyte_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            nack_q, nack_d;
  logic            rd_ok_q, rd_ok_d;
  logic            sda_q, sda_d;
  logic            done_q, done_d;
  logic            ack_err_q, ack_err_d;
  logic            rd_valid_q, rd_valid_d;

  logic            scl_in, sda_in;
  logic            accept, stall, tick, smp, end_bit;
  logic            scl_low;
  logic [2:0]      sel;

  assign scl_in = SCL;
  assign sda_in = SDA;

  assign CMD_READY = (state_q == S_IDLE) && !done_q;
  assign BUSY      = !CMD_READY;
  assign DONE      = done_q;
  assign ACK_ERR   = ack_err_q;
  assign RD_VALID  = rd_valid_q;
  assign RD_DATA   = rd_data_q;

  assign SCL = scl_low ? 1'b0 : 1'bz;
  assign SDA = sda_q ? 1'b0 : 1'bz;

  always_ff @(posedge CLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      qtr_q      <= 2'd0;
      bit_q      <= 3'd0;
      abyte_q    <= 8'h00;
      wdata_q    <= 8'h00;
      shreg_q    <= 8'h00;
      rd_data_q  <= 8'h00;
      nack_q     <= 1'b0;
      rd_ok_q    <= 1'b0;
      sda_q      <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      abyte_q    <= abyte_d;
      wdata_q    <= wdata_d;
      shreg_q    <= shreg_d;
      rd_data_q  <= rd_data_d;
      nack_q     <= nack_d;
      rd_ok_q    <= rd_ok_d;
      sda_q      <= sda_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Divider freezes in Q2 while a slave holds SCL low
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    abyte_d    = abyte_q;
    wdata_d    = wdata_q;
    shreg_d    = shreg_q;
    rd_data_d  = rd_data_q;
    nack_d     = nack_q;
    rd_ok_d    = rd_ok_q;
    done_d     = 1'b0;
    ack_err_d  = 1'b0;
    rd_valid_d = 1'b0;

    accept  = CMD_VALID && CMD_READY;
    stall   = (qtr_q == 2'd2) && !scl_in;
    tick    = (state_q != S_IDLE) && !stall && (div_q == DIV_LAST);
    smp     = tick && (qtr_q == 2'd2);
    end_bit = tick && (qtr_q == 2'd3);

    if (state_q != S_IDLE && !stall)
      div_d = tick ? '0 : div_q + 1'b1;
    if (tick)
      qtr_d = qtr_q + 2'd1;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          abyte_d = {CMD_ADDR, CMD_RW};
          wdata_d = CMD_WDATA;
          div_d   = '0;
          qtr_d   = 2'd0;
          bit_d   = 3'd0;
          nack_d  = 1'b0;
          rd_ok_d = 1'b0;
        end
      end
      S_START: begin
        if (end_bit)
          state_d = S_ADDR;
      end
      S_ADDR: begin
        if (end_bit) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7)
            state_d = S_ADDR_ACK;
        end
      end
      S_ADDR_ACK: begin
        if (smp) begin
          nack_d    = sda_in;
          ack_err_d = sda_in;
        end
        if (end_bit) begin
          rd_ok_d = !nack_q && abyte_q[0];
          if (nack_q)
            state_d = S_STOP;
          else
            state_d = abyte_q[0] ? S_READ : S_WRITE;
        end
      end
      S_WRITE: begin
        if (end_bit) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7)
            state_d = S_WRITE_ACK;
        end
      end
      S_WRITE_ACK: begin
        if (smp)
          ack_err_d = sda_in;
        if (end_bit)
          state_d = S_STOP;
      end
      S_READ: begin
        if (smp)
          shreg_d = LSB_FIRST ? {sda_in, shreg_q[7:1]}
                              : {shreg_q[6:0], sda_in};
        if (end_bit) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7)
            state_d = S_READ_ACK;
        end
      end
      S_READ_ACK: begin
        if (end_bit)
          state_d = S_STOP;
      end
      S_STOP: begin
        if (end_bit) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (rd_ok_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = shreg_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // SDA target is computed for the quarter being entered; Q0 keeps the old level
  always_comb begin
    scl_low = 1'b0;
    sel     = LSB_FIRST ? bit_d : 3'd7 - bit_d;
    sda_d   = 1'b0;

    unique case (state_q)
      S_IDLE:  scl_low = 1'b0;
      S_START: scl_low = (qtr_q == 2'd3);
      S_STOP:  scl_low = (qtr_q == 2'd0);
      default: scl_low = (qtr_q < 2'd2);
    endcase

    unique case (state_d)
      S_IDLE:  sda_d = 1'b0;
      S_START: sda_d = qtr_d[1];
      S_ADDR:  sda_d = (qtr_d == 2'd0) ? sda_q : ~abyte_q[sel];
      S_WRITE: sda_d = (qtr_d == 2'd0) ? sda_q : ~wdata_q[sel];
      S_STOP:  sda_d = (qtr_d != 2'd3);
      default: sda_d = (qtr_d == 2'd0) ? sda_q : 1'b0;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: behavioural slave on a pulled-up bus,
// vector table, randomized transactions and multi-cycle corner sequences.
module tb_i2c_master_ctrl;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = 7'h00;
  logic [7:0] cmd_wdata = 8'h00;
  wire        cmd_ready, rd_valid, done, ack_err, busy;
  wire  [7:0] rd_data;
  wire        scl, sda;

  logic       stretch = 1'b0;
  logic       sl_sda = 1'b0;

  pullup (scl);
  pullup (sda);
  assign scl = stretch ? 1'b0 : 1'bz;
  assign sda = sl_sda ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV), .LSB_FIRST(1'b1)) dut (
    .CLK(clk), .RESET_IN(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_RW(cmd_rw), .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
    .RD_DATA(rd_data), .RD_VALID(rd_valid), .DONE(done),
    .ACK_ERR(ack_err), .BUSY(busy), .SCL(scl), .SDA(sda)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural slave: counts SCL rising edges after START (LSB first)
  logic       s_active = 1'b0;
  int         s_cnt = 0;
  logic [7:0] s_addr = 8'h00;
  logic [7:0] s_data = 8'h00;
  logic       s_ack_addr = 1'b1;
  logic       s_ack_data = 1'b1;
  logic [7:0] s_rbyte = 8'h00;

  always @(negedge sda) begin
    if (scl === 1'b1) begin
      s_active = 1'b1;
      s_cnt    = 0;
      s_addr   = 8'h00;
      s_data   = 8'h00;
      sl_sda   = 1'b0;
    end
  end

  always @(posedge sda) begin
    if (scl === 1'b1) begin
      s_active = 1'b0;
      sl_sda   = 1'b0;
    end
  end

  always @(posedge scl) begin
    if (s_active) begin
      s_cnt++;
      if (s_cnt <= 8)
        s_addr = {sda, s_addr[7:1]};
      else if (s_cnt >= 10 && s_cnt <= 17 && !s_addr[0])
        s_data = {sda, s_data[7:1]};
    end
  end

  always @(negedge scl) begin : slv_drive
    int n;
    if (s_active) begin
      n = s_cnt + 1;
      if (n == 9)
        sl_sda = s_ack_addr;
      else if (n >= 10 && n <= 17 && s_addr[0] && s_ack_addr)
        sl_sda = ~s_rbyte[3'(n - 10)];
      else if (n == 18 && !s_addr[0])
        sl_sda = s_ack_data;
      else
        sl_sda = 1'b0;
    end
  end

  // SDA edges seen while SCL stays high (only START and STOP allowed)
  logic p_scl, p_sda;
  int   hi_fall = 0;
  int   hi_rise = 0;

  always @(negedge clk) begin
    if (p_scl === 1'b1 && scl === 1'b1 && p_sda !== sda) begin
      if (sda === 1'b0) hi_fall++;
      else hi_rise++;
    end
    p_scl = scl;
    p_sda = sda;
  end

  task automatic do_txn(input string nm, input logic rw,
                        input logic [6:0] addr, input logic [7:0] wd,
                        input logic aa, input logic ad,
                        input logic [7:0] rb, input int st_k,
                        input int e_done, input int e_aerr,
                        input int e_aek, input int e_rv,
                        input logic [7:0] e_rd);
    int   done_k, aerr_n, aerr_k, rv_n;
    logic rv_ok, sda_ack;
    s_ack_addr = aa;
    s_ack_data = ad;
    s_rbyte    = rb;
    @(negedge clk);
    chk({nm, ".ready"}, 32'(cmd_ready), 32'd1);
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    hi_fall = 0;
    hi_rise = 0;
    done_k  = -1;
    aerr_n  = 0;
    aerr_k  = -1;
    rv_n    = 0;
    rv_ok   = 1'b0;
    sda_ack = 1'bx;
    for (int k = 0; k < 1000 && done_k < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (st_k >= 0 && k == st_k) stretch = 1'b1;
      if (st_k >= 0 && k == st_k + 11) stretch = 1'b0;
      if (ack_err) begin
        aerr_n++;
        aerr_k = k;
      end
      if (rd_valid) begin
        rv_n++;
        rv_ok = done;
      end
      if (k == 298) sda_ack = sda;
      if (done) done_k = k;
    end
    stretch = 1'b0;
    chk({nm, ".done_cycle"}, 32'(done_k), 32'(e_done));
    chk({nm, ".ack_err_pulses"}, 32'(aerr_n), 32'(e_aerr));
    if (e_aerr != 0)
      chk({nm, ".ack_err_cycle"}, 32'(aerr_k), 32'(e_aek));
    chk({nm, ".rd_valid_pulses"}, 32'(rv_n), 32'(e_rv));
    if (e_rv != 0) begin
      chk({nm, ".rd_valid_with_done"}, 32'(rv_ok), 32'd1);
      chk({nm, ".sda_nack_released"}, 32'(sda_ack), 32'd1);
    end
    chk({nm, ".rd_data"}, 32'(rd_data), 32'(e_rd));
    chk({nm, ".slave_addr_byte"}, 32'(s_addr), 32'({addr, rw}));
    if (!rw && aa)
      chk({nm, ".slave_data"}, 32'(s_data), 32'(wd));
    chk({nm, ".start_edges"}, 32'(hi_fall), 32'd1);
    chk({nm, ".stop_edges"}, 32'(hi_rise), 32'd1);
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wd;
    logic       aa;
    logic       ad;
    logic [7:0] rb;
    int         e_done;
    int         e_aerr;
    int         e_aek;
    int         e_rv;
    logic [7:0] e_rd;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] model_rd;
  logic       r_rw, r_aa, r_ad;
  logic [6:0] r_addr;
  logic [7:0] r_wd, r_rb;
  int         e_done, e_aerr, e_aek, e_rv;
  int         n_done;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 320, 0, 0,   0, 8'h00};
    tbl[1] = '{1'b1, 7'h50, 8'h00, 1'b1, 1'b1, 8'h3C, 320, 0, 0,   1, 8'h3C};
    tbl[2] = '{1'b0, 7'h50, 8'hA5, 1'b0, 1'b1, 8'h00, 176, 1, 156, 0, 8'h3C};
    tbl[3] = '{1'b1, 7'h23, 8'h00, 1'b0, 1'b1, 8'hFF, 176, 1, 156, 0, 8'h3C};
    tbl[4] = '{1'b0, 7'h7F, 8'h00, 1'b1, 1'b0, 8'h00, 320, 1, 300, 0, 8'h3C};
    tbl[5] = '{1'b1, 7'h01, 8'h00, 1'b1, 1'b1, 8'h81, 320, 0, 0,   1, 8'h81};

    repeat (3) @(negedge clk);
    chk("rst.ready", 32'(cmd_ready), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.rd_valid", 32'(rd_valid), 32'd0);
    chk("rst.ack_err", 32'(ack_err), 32'd0);
    chk("rst.rd_data", 32'(rd_data), 32'h00);
    chk("rst.scl", 32'(scl), 32'd1);
    chk("rst.sda", 32'(sda), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      do_txn($sformatf("vec%0d", i), tbl[i].rw, tbl[i].addr, tbl[i].wd,
             tbl[i].aa, tbl[i].ad, tbl[i].rb, -1, tbl[i].e_done,
             tbl[i].e_aerr, tbl[i].e_aek, tbl[i].e_rv, tbl[i].e_rd);
    model_rd = 8'h81;

    // Reference model: bit budget per transaction, errors from ACK rules
    for (int i = 0; i < 20; i++) begin
      r_rw   = 1'($urandom_range(0, 1));
      r_addr = 7'($urandom);
      r_wd   = 8'($urandom);
      r_rb   = 8'($urandom);
      r_aa   = ($urandom_range(0, 3) != 0);
      r_ad   = ($urandom_range(0, 3) != 0);
      e_done = 4 * CLK_DIV * (r_aa ? (1 + 9 + 9 + 1) : (1 + 9 + 1));
      e_aerr = (!r_aa || (!r_rw && !r_ad)) ? 1 : 0;
      e_aek  = (4 * (r_aa ? 18 : 9) + 3) * CLK_DIV;
      e_rv   = (r_rw && r_aa) ? 1 : 0;
      if (e_rv != 0) model_rd = r_rb;
      do_txn($sformatf("rnd%0d", i), r_rw, r_addr, r_wd, r_aa, r_ad,
             r_rb, -1, e_done, e_aerr, e_aek, e_rv, model_rd);
    end

    do_txn("stretch", 1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 71,
           330, 0, 0, 0, model_rd);

    s_ack_addr = 1'b1;
    s_ack_data = 1'b1;
    @(negedge clk);
    cmd_rw    = 1'b0;
    cmd_addr  = 7'h50;
    cmd_wdata = 8'hA5;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (226) @(negedge clk);
    chk("rstmid.scl_before", 32'(scl), 32'd0);
    chk("rstmid.sda_before", 32'(sda), 32'd0);
    rst = 1'b1;
    #1;
    chk("rstmid.scl_released", 32'(scl), 32'd1);
    chk("rstmid.sda_released", 32'(sda), 32'd1);
    chk("rstmid.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid.ready", 32'(cmd_ready), 32'd1);
    model_rd = 8'h00;
    do_txn("after_rst", 1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, -1,
           320, 0, 0, 0, model_rd);

    @(negedge clk);
    cmd_rw    = 1'b0;
    cmd_addr  = 7'h50;
    cmd_wdata = 8'hA5;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_done = 0;
    for (int k = 0; k < 700; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 100) begin
        chk("busy_cmd.busy", 32'(busy), 32'd1);
        cmd_addr  = 7'h11;
        cmd_wdata = 8'h5A;
        cmd_valid = 1'b1;
      end
      if (k == 101) cmd_valid = 1'b0;
      if (done) n_done++;
    end
    chk("busy_cmd.done_count", 32'(n_done), 32'd1);
    chk("busy_cmd.slave_addr", 32'(s_addr), 32'hA0);
    chk("busy_cmd.slave_data", 32'(s_data), 32'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
